dcache_write_buffer: RTL and testbench
======================================

Name: dcache_write_buffer

Overview:
- Posted-write buffer between the data cache's memory-side port and data memory.
- Absorbs dirty-block write-backs so the data cache does not stall on a write, drains them to memory in the background, and lets block reads bypass buffered writes.
- Reads that hit a buffered block are forwarded from the buffer.
- Upstream and downstream ports both use the codebase's 6-bit block address / 32-bit block data / busywait handshake.

Parameters:
- DEPTH, 4, number of buffered write entries (power of two, minimum 2).
- ADDR_W, 6, block address width.
- DATA_W, 32, block data width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- c_read  in  1  block read request from the data cache.
- c_write  in  1  block write request from the data cache.
- c_address  in  ADDR_W  block address of the request.
- c_writedata  in  DATA_W  block data for a write.
- c_readdata  out  DATA_W  block data returned for a read.
- c_busywait  out  1  stall to the data cache (combinational).
- mem_read  out  1  read strobe to data memory (registered).
- mem_write  out  1  write strobe to data memory (registered).
- mem_address  out  ADDR_W  address to data memory (registered).
- mem_writedata  out  DATA_W  write data to data memory (registered).
- mem_readdata  in  DATA_W  read data from data memory.
- mem_busywait  in  1  data memory busy.
- wb_empty  out  1  high when no entries are held and no memory operation is in flight.

Behaviour:
- Reset (RESET=0, takes effect immediately, asynchronous):
  - All entries invalid; count 0.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - FSM=IDLE, rd_valid=0, c_readdata=0, wb_empty=1.
  - Any in-flight memory operation is abandoned; buffered data is lost.
- Storage:
  - Circular FIFO of DEPTH entries {valid, addr, data}, with head/tail pointers that wrap modulo DEPTH.
  - full = (count==DEPTH).
- Write accept:
  - On a rising edge with c_write=1, c_read=0 and not full:
    - If c_address matches a valid entry other than the head entry currently being drained, that entry's data is overwritten (coalesced) and count is unchanged.
    - Otherwise the request is enqueued at the tail.
  - c_busywait = c_write & full.
  - A write is never accepted while full, even if a drain completes on the same edge; it is accepted on the next edge.
- Read:
  - c_read=1 with an address match on a valid entry:
    - c_readdata = data of the youngest matching entry (combinational forward).
    - c_busywait=0 in the same cycle; no memory access.
  - c_read=1 with no match: c_busywait stays 1 until rd_valid.
- Read/write precedence: c_read and c_write together is illegal; the read is serviced and the write is ignored.
- FSM IDLE:
  - Read miss pending: go to READ; drive mem_read=1 and mem_address=c_address. Read has priority over drain.
  - Else, if count>0: go to DRAIN; drive mem_write=1, mem_address/mem_writedata = head entry.
- Memory handshake:
  - A memory operation completes at the first rising edge where mem_busywait is sampled 0 after having been sampled 1 since issue.
  - On that same edge, the strobe is deasserted and the FSM returns to IDLE.
- DRAIN completion: head entry invalidated, head pointer advances, count decrements.
- READ completion:
  - mem_readdata is latched into the read data register and rd_valid=1 for exactly one cycle.
  - In that cycle c_busywait=0 and c_readdata = the latched data.
  - rd_valid clears on the next edge.
- Simultaneous events:
  - An enqueue on the edge a drain completes: count is unchanged, both pointers advance.
  - A write arriving while DRAIN is in flight to the same address: enqueued as a new entry, not coalesced.
- Outputs:
  - wb_empty = (count==0) & (FSM==IDLE).
  - Minimum write-back latency through an empty buffer: issue on the edge after accept.

Test Plan:
- Reset mid-DRAIN:
  - Stimulus: 2 writes, then RESET=0 for 1 ns during mem_write=1.
  - Required response: mem_write drops immediately, wb_empty=1, no further memory writes after release.
- Posted write:
  - Stimulus: write addr 0x05 data 0xDEADBEEF with memory busy for 5 cycles.
  - Required response: c_busywait stays 0; one mem_write at 0x05 with 0xDEADBEEF; wb_empty=1 after completion.
- Full stall:
  - Stimulus: 5 back-to-back writes to 0x01..0x05 with DEPTH=4.
  - Required response: c_busywait=1 on the 5th write until the first drain completes; memory sees 0x01..0x05 in order.
- Coalesce:
  - Stimulus: writes 0x10/0x11111111, 0x12/0x22222222, 0x12/0x33333333 while memory is stalled on 0x10.
  - Required response: only two further memory writes occur, and 0x12 is written with 0x33333333.
- Forward hit:
  - Stimulus: write 0x20/0xCAFEF00D, then immediately read 0x20.
  - Required response: c_busywait=0 and c_readdata=0xCAFEF00D the same cycle; no mem_read issued.
- Read bypass:
  - Stimulus: buffer holds 0x01 and 0x02; read 0x30 (memory holds 0xA5A5A5A5).
  - Required response: mem_read at 0x30 issued before the remaining drain; one cycle with c_busywait=0 and c_readdata=0xA5A5A5A5; drains resume afterwards.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the data cache and data memory: absorbs block write-backs,
// drains them in the background, forwards reads that hit and lets read misses bypass drains.
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_address,
    input  logic [DATA_W-1:0] c_writedata,
    output logic [DATA_W-1:0] c_readdata,
    output logic              c_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              wb_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    ptr_t              head;
    ptr_t              tail;
    cnt_t              count;
    logic              seen_busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              full;
    logic              hit;
    logic              coalesce;
    logic              drain_busy;
    logic              read_miss;
    logic              accept;
    logic              enq;
    logic              op_done;
    logic              drain_done;
    logic              start_read;
    logic              start_drain;
    logic [DATA_W-1:0] fwd_data;
    ptr_t              co_idx;
    ptr_t              idx;

    assign full       = (count == cnt_t'(DEPTH));
    // The head may be handed to memory on this very edge; it must not absorb a coalesced write.
    assign drain_busy = (state == DRAIN) || (state == IDLE && count != '0);
    assign read_miss  = c_read && !hit && !rd_valid;
    assign accept     = c_write && !c_read && !full;
    assign enq        = accept && !coalesce;
    assign op_done    = (state != IDLE) && seen_busy && !mem_busywait;
    assign drain_done = op_done && (state == DRAIN);

    assign c_busywait = c_read ? !(hit || rd_valid) : (c_write && full);
    assign c_readdata = (hit && !rd_valid) ? fwd_data : rd_data;
    assign wb_empty   = (count == '0) && (state == IDLE);

    // Valid entries are contiguous from head, so scanning oldest to youngest leaves the youngest match.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        hit      = 1'b0;
        coalesce = 1'b0;
        fwd_data = '0;
        co_idx   = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + ptr_t'(i);
            if (valid[idx] && addr_q[idx] == c_address) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
                if (!(idx == head && drain_busy)) begin
                    coalesce = 1'b1;
                    co_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        start_read  = 1'b0;
        start_drain = 1'b0;
        case (state)
            IDLE: begin
                if (read_miss) begin
                    state_nxt  = READ;
                    start_read = 1'b1;
                end else if (count != '0) begin
                    state_nxt   = DRAIN;
                    start_drain = 1'b1;
                end
            end
            READ, DRAIN: if (op_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            seen_busy     <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
        end else begin
            state    <= state_nxt;
            rd_valid <= 1'b0;
            if (start_read) begin
                mem_read    <= 1'b1;
                mem_address <= c_address;
                seen_busy   <= 1'b0;
            end else if (start_drain) begin
                mem_write     <= 1'b1;
                mem_address   <= addr_q[head];
                mem_writedata <= data_q[head];
                seen_busy     <= 1'b0;
            end else if (op_done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                seen_busy <= 1'b0;
                if (state == READ) begin
                    rd_data  <= mem_readdata;
                    rd_valid <= 1'b1;
                end
            end else if (state != IDLE && mem_busywait) begin
                seen_busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + ptr_t'(1);
            end
            if (drain_done) begin
                valid[head] <= 1'b0;
                head        <= head + ptr_t'(1);
            end
            count <= count + cnt_t'(enq) - cnt_t'(drain_done);
        end
    end

    // NOTE: entry payload is not reset; the valid bits alone decide whether it is ever observed.
    always_ff @(posedge CLK) begin
        if (enq) begin
            addr_q[tail] <= c_address;
            data_q[tail] <= c_writedata;
        end else if (accept) begin
            data_q[co_idx] <= c_writedata;
        end
    end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer: a queue-level model of pending writes predicts
// memory writes and read responses; separate monitors compare whenever the DUT presents them.
module tb_dcache_write_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              c_read = 1'b0;
    logic              c_write = 1'b0;
    logic [ADDR_W-1:0] c_address = '0;
    logic [DATA_W-1:0] c_writedata = '0;
    logic [DATA_W-1:0] c_readdata;
    logic              c_busywait;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic              mem_busywait = 1'b0;
    logic              wb_empty;

    dcache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .c_read(c_read), .c_write(c_write), .c_address(c_address),
        .c_writedata(c_writedata), .c_readdata(c_readdata), .c_busywait(c_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait), .wb_empty(wb_empty)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: pending writes in drain order, the entry memory is working on, and memory contents.
    wr_t               wq[$];
    wr_t               inflight;
    bit                inflight_v = 1'b0;
    logic [DATA_W-1:0] rd_exp[$];
    logic [ADDR_W-1:0] rd_addr_exp[$];
    logic [DATA_W-1:0] mem_arr [64];
    int                lat = 3;
    int                wr_issues = 0;
    int                rd_issues = 0;
    int                exp_rd_issues = 0;
    int                q_at_read = -1;
    bit                last_stalled = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        return wq.size() + (inflight_v ? 1 : 0);
    endfunction

    function automatic bit model_lookup(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        d = '0;
        for (int i = wq.size() - 1; i >= 0; i--) begin
            if (wq[i].addr == a) begin
                d = wq[i].data;
                return 1'b1;
            end
        end
        if (inflight_v && inflight.addr == a) begin
            d = inflight.data;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        for (int i = wq.size() - 1; i >= 0; i--) begin
            if (wq[i].addr == a) begin
                wq[i].data = d;
                return;
            end
        end
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endfunction

    // Data memory: busy for 'lat' cycles per operation, writes land at issue, reads return at the end.
    int mem_cnt = 0;
    bit mem_active = 1'b0;
    always @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_active   = 1'b0;
            mem_busywait = 1'b0;
            mem_cnt      = 0;
        end else if (mem_active) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_busywait = 1'b0;
                mem_active   = 1'b0;
                if (mem_read) mem_readdata = mem_arr[mem_address];
            end
        end else if (mem_read || mem_write) begin
            mem_active   = 1'b1;
            mem_busywait = 1'b1;
            mem_cnt      = lat;
            if (mem_write) mem_arr[mem_address] = mem_writedata;
        end
    end

    // Memory-side monitor: each new write strobe must carry the oldest pending model entry.
    bit prev_w = 1'b0;
    bit prev_r = 1'b0;
    always @(posedge CLK) begin
        wr_t e;
        #1;
        if (mem_write && !prev_w) begin
            wr_issues++;
            check("mem_wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check("mem_wr_addr", 64'(mem_address), 64'(e.addr));
                check("mem_wr_data", 64'(mem_writedata), 64'(e.data));
                inflight   = e;
                inflight_v = 1'b1;
            end
        end
        if (!mem_write && prev_w) inflight_v = 1'b0;
        if (mem_read && !prev_r) begin
            rd_issues++;
            q_at_read = wq.size();
            check("mem_rd_expected", 64'(rd_addr_exp.size() != 0), 64'd1);
            if (rd_addr_exp.size() != 0) check("mem_rd_addr", 64'(mem_address), 64'(rd_addr_exp.pop_front()));
        end
        prev_w = mem_write;
        prev_r = mem_read;
    end

    // Cache-side monitor: a read response is presented whenever c_read is high and busywait is low.
    always @(negedge CLK) begin
        #2;
        if (c_read && !c_busywait) begin
            check("rd_expected", 64'(rd_exp.size() != 0), 64'd1);
            if (rd_exp.size() != 0) check("c_readdata", 64'(c_readdata), 64'(rd_exp.pop_front()));
        end
    end

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        @(negedge CLK);
        c_write     = 1'b1;
        c_read      = 1'b0;
        c_address   = a;
        c_writedata = d;
        #1;
        check("wr_busywait", 64'(c_busywait), 64'(model_count() == DEPTH));
        last_stalled = c_busywait;
        n = 0;
        while (c_busywait && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("wr_accepted", 64'(c_busywait), 64'd0);
        @(posedge CLK);
        #2;
        model_write(a, d);
        c_write = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        int n;
        bit h;
        logic [DATA_W-1:0] d;
        @(negedge CLK);
        c_read    = 1'b1;
        c_write   = 1'b0;
        c_address = a;
        h = model_lookup(a, d);
        if (!h) begin
            d = mem_arr[a];
            rd_addr_exp.push_back(a);
            exp_rd_issues++;
        end
        rd_exp.push_back(d);
        #1;
        check("rd_busywait", 64'(c_busywait), 64'(!h));
        n = 0;
        while (c_busywait && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("rd_served", 64'(c_busywait), 64'd0);
        @(posedge CLK);
        #2;
        c_read = 1'b0;
    endtask

    task automatic idle(input int n);
        c_read  = 1'b0;
        c_write = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_empty();
        int n;
        c_read  = 1'b0;
        c_write = 1'b0;
        n = 0;
        @(negedge CLK);
        #1;
        while (!wb_empty && n < 500) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("wb_empty_drained", 64'(wb_empty), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0;
        int r0;
        logic [DATA_W-1:0] d2;
        for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;

        // Reset values
        #1 RESET = 1'b0;
        #1;
        check("rst_wb_empty", 64'(wb_empty), 64'd1);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_mem_writedata", 64'(mem_writedata), 64'd0);
        check("rst_c_readdata", 64'(c_readdata), 64'd0);
        check("rst_c_busywait", 64'(c_busywait), 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        // Posted write through an empty buffer with a slow memory
        lat = 5;
        do_write(6'h05, 32'hDEADBEEF);
        wait_empty();
        check("posted_mem_content", 64'(mem_arr[6'h05]), 64'hDEADBEEF);
        check("posted_one_write", 64'(wr_issues), 64'd1);

        // Full stall: fifth back-to-back write must wait for the first drain
        lat = 4;
        for (int i = 1; i <= 5; i++) do_write(ADDR_W'(i), 32'h1000_0000 + 32'(i));
        check("full_stall_seen", 64'(last_stalled), 64'd1);
        wait_empty();
        check("full_mem_05", 64'(mem_arr[6'h05]), 64'h1000_0005);

        // Coalesce into a queued entry while memory is stalled on 0x10
        lat = 6;
        w0 = wr_issues;
        do_write(6'h10, 32'h11111111);
        do_write(6'h12, 32'h22222222);
        do_write(6'h12, 32'h33333333);
        wait_empty();
        check("coalesce_write_count", 64'(wr_issues - w0), 64'd2);
        check("coalesce_mem_12", 64'(mem_arr[6'h12]), 64'h33333333);

        // Forward hit: no memory read
        lat = 3;
        r0 = rd_issues;
        do_write(6'h20, 32'hCAFEF00D);
        do_read(6'h20);
        check("fwd_no_mem_read", 64'(rd_issues), 64'(r0));
        wait_empty();

        // Read bypass: miss is issued while 0x02 is still waiting to drain
        mem_arr[6'h30] = 32'hA5A5A5A5;
        lat = 5;
        d2 = $urandom;
        do_write(6'h01, $urandom);
        do_write(6'h02, d2);
        do_read(6'h30);
        check("bypass_before_drain", 64'(q_at_read), 64'd1);
        wait_empty();
        check("bypass_drain_resumed", 64'(mem_arr[6'h02]), 64'(d2));

        // Reset in the middle of a drain
        lat = 6;
        do_write(6'h07, $urandom);
        do_write(6'h08, $urandom);
        @(negedge CLK);
        check("pre_rst_mem_write", 64'(mem_write), 64'd1);
        #2 RESET = 1'b0;
        #1;
        check("rst_mid_mem_write", 64'(mem_write), 64'd0);
        check("rst_mid_wb_empty", 64'(wb_empty), 64'd1);
        RESET = 1'b1;
        wq.delete();
        rd_exp.delete();
        rd_addr_exp.delete();
        inflight_v = 1'b0;
        w0 = wr_issues;
        idle(20);
        check("no_write_after_reset", 64'(wr_issues), 64'(w0));
        check("rst_stays_empty", 64'(wb_empty), 64'd1);

        // Randomized traffic over a small address window to exercise hits and coalescing
        for (int k = 0; k < 300; k++) begin
            int r;
            lat = $urandom_range(1, 4);
            r = $urandom_range(0, 9);
            if (r < 6)      do_write(ADDR_W'($urandom_range(0, 15)), $urandom);
            else if (r < 9) do_read(ADDR_W'($urandom_range(0, 15)));
            else            idle($urandom_range(1, 6));
        end
        wait_empty();
        check("final_rd_issues", 64'(rd_issues), 64'(exp_rd_issues));
        check("final_model_empty", 64'(model_count()), 64'd0);
        check("final_rd_drained", 64'(rd_exp.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
